// File: rtl/display_pkg.sv
// display_pkg
// Shared constants and types for the hex display pager:
//   - active-low 7-segment glyphs for digits 0..F (bit 0 = segment a) and SEG_BLANK
//   - LEDR bit positions
//   - conversion FSM state type
//   - seg_of():     nibble to glyph
//   - bcd_adjust(): one add-3 correction step over three BCD digits
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int unsigned LEDR_MATCH    = 0;
    localparam int unsigned LEDR_HALT     = 1;
    localparam int unsigned LEDR_STATE_LO = 2;
    localparam int unsigned LEDR_PAGE_LO  = 4;

    // Wide enough for page indices 0..5.
    localparam int unsigned PAGE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } conv_state_t;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

    function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential shift-add-3 binary-to-BCD converter. The FSM runs
// IDLE -> LOAD -> SHIFT (DATA_W cycles) -> DONE, then returns to IDLE. If
// start_i is high while in DONE, it goes straight back to LOAD.
// The result register is written on the final SHIFT edge, so it is valid
// during DONE and holds until the next conversion completes.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   start_i       request a conversion (accepted in IDLE or DONE)
//   bin_i, tag_i  value to convert and an opaque tag carried with it
//   busy_o        high in LOAD, SHIFT and DONE
//   done_o        high in DONE
//   valid_o       a result has been produced since reset
//   bcd_o         {hundreds, tens, ones} of the last result
//   tag_o         tag of the last result
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] bin_i,
    input  logic [PAGE_W-1:0] tag_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              valid_o,
    output logic [11:0]       bcd_o,
    output logic [PAGE_W-1:0] tag_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    conv_state_t       state_q;
    logic [DATA_W-1:0] bin_q;
    logic [DATA_W-1:0] sh_q;
    logic [PAGE_W-1:0] tag_q;
    logic [PAGE_W-1:0] res_tag_q;
    logic [11:0]       bcd_q;
    logic [11:0]       res_q;
    logic              res_valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [11:0]       adj;
    logic [11:0]       bcd_step;

    always_comb begin
        adj      = bcd_adjust(bcd_q);
        bcd_step = {adj[10:0], sh_q[DATA_W-1]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            sh_q        <= '0;
            tag_q       <= '0;
            res_tag_q   <= '0;
            bcd_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        bin_q   <= bin_i;
                        tag_q   <= tag_i;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    sh_q    <= bin_q;
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    bcd_q <= bcd_step;
                    sh_q  <= {sh_q[DATA_W-2:0], 1'b0};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        // Publish the final shift directly so the result is visible in DONE.
                        res_q       <= bcd_step;
                        res_tag_q   <= tag_q;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (start_i) begin
                        bin_q   <= bin_i;
                        tag_q   <= tag_i;
                        state_q <= ST_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = (state_q == ST_DONE);
    assign valid_o = res_valid_q;
    assign bcd_o   = res_q;
    assign tag_o   = res_tag_q;

endmodule

// File: rtl/display_hex_pager.sv
// display_hex_pager
// Pages through NUM_CH channel values and shows the selected one in decimal
// on HEX2..HEX0, with the page number on HEX5.
// Ports:
//   clk, reset      clock, async active-high reset
//   ch_data         packed channel values, ch0 in the LSBs
//   page_next       one-cycle pulse that advances the page
//   auto_rotate     level; advance the page every ROTATE_TICKS cycles
//   match_signal    stretched onto LEDR[0] for FLASH_TICKS cycles
//   halt_signal     freezes paging, the rotate timer and new conversions
//   state           engine state, mirrored onto LEDR[3:2]
//   HEX0..HEX5      active-low 7-segment outputs
//   LEDR            status LEDs: [0] match, [1] halt, [3:2] state, [9:4] one-hot page
//   busy            conversion in progress
module display_hex_pager
    import display_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned ROTATE_TICKS = 50_000_000,
    parameter int unsigned FLASH_TICKS  = 12_500_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     page_next,
    input  logic                     auto_rotate,
    input  logic                     match_signal,
    input  logic                     halt_signal,
    input  logic [1:0]               state,
    output logic [6:0]               HEX0,
    output logic [6:0]               HEX1,
    output logic [6:0]               HEX2,
    output logic [6:0]               HEX3,
    output logic [6:0]               HEX4,
    output logic [6:0]               HEX5,
    output logic [9:0]               LEDR,
    output logic                     busy
);

    localparam int unsigned ROT_W = $clog2(ROTATE_TICKS);
    localparam int unsigned FL_W  = $clog2(FLASH_TICKS + 1);

    logic [PAGE_W-1:0] page_q, page_d;
    logic [ROT_W-1:0]  rot_q, rot_d;
    logic [FL_W-1:0]   fl_q, fl_d;
    logic [9:0]        ledr_q, ledr_d;
    logic [DATA_W-1:0] snap_val_q;
    logic [PAGE_W-1:0] snap_page_q;
    logic              snap_valid_q;

    logic [DATA_W-1:0] sel_val;
    logic              expire, advance, start, accept;

    logic              conv_busy, conv_done, conv_valid;
    logic [11:0]       conv_bcd;
    logic [PAGE_W-1:0] conv_tag;

    always_comb begin
        expire  = auto_rotate && !halt_signal && (rot_q == ROT_W'(ROTATE_TICKS - 1));
        advance = (page_next && !halt_signal) || expire;

        page_d = page_q;
        if (advance) begin
            page_d = (page_q == PAGE_W'(NUM_CH - 1)) ? '0 : page_q + PAGE_W'(1);
        end

        rot_d = rot_q;
        if (!auto_rotate || advance) begin
            rot_d = '0;
        end else if (!halt_signal) begin
            rot_d = rot_q + ROT_W'(1);
        end

        // Select on the next page so a page change triggers in the same cycle it happens.
        sel_val = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (page_d == PAGE_W'(i)) begin
                sel_val = ch_data[i*DATA_W +: DATA_W];
            end
        end

        // Level-sensitive start: anything that arrives mid-conversion is still pending at DONE.
        start  = !halt_signal &&
                 (!snap_valid_q || (page_d != snap_page_q) || (sel_val != snap_val_q));
        accept = start && (!conv_busy || conv_done);

        fl_d = fl_q;
        if (match_signal) begin
            fl_d = FL_W'(FLASH_TICKS);
        end else if (fl_q != '0) begin
            fl_d = fl_q - FL_W'(1);
        end

        ledr_d                         = '0;
        ledr_d[LEDR_MATCH]             = (fl_d != '0);
        ledr_d[LEDR_HALT]              = halt_signal;
        ledr_d[LEDR_STATE_LO +: 2]     = state;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ledr_d[LEDR_PAGE_LO + i] = (page_d == PAGE_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page_q       <= '0;
            rot_q        <= '0;
            fl_q         <= '0;
            ledr_q       <= '0;
            snap_val_q   <= '0;
            snap_page_q  <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            page_q <= page_d;
            rot_q  <= rot_d;
            fl_q   <= fl_d;
            ledr_q <= ledr_d;
            if (accept) begin
                snap_val_q   <= sel_val;
                snap_page_q  <= page_d;
                snap_valid_q <= 1'b1;
            end
        end
    end

    bin2bcd_seq #(
        .DATA_W(DATA_W)
    ) u_bin2bcd (
        .clk_i  (clk),
        .rst_i  (reset),
        .start_i(start),
        .bin_i  (sel_val),
        .tag_i  (page_d),
        .busy_o (conv_busy),
        .done_o (conv_done),
        .valid_o(conv_valid),
        .bcd_o  (conv_bcd),
        .tag_o  (conv_tag)
    );

    // Digits and page number all come from the converter's result register, so they change together.
    always_comb begin
        HEX0 = SEG_BLANK;
        HEX1 = SEG_BLANK;
        HEX2 = SEG_BLANK;
        HEX5 = SEG_BLANK;
        if (conv_valid) begin
            HEX0 = seg_of(conv_bcd[3:0]);
            if (conv_bcd[11:4] != 8'h00) begin
                HEX1 = seg_of(conv_bcd[7:4]);
            end
            if (conv_bcd[11:8] != 4'h0) begin
                HEX2 = seg_of(conv_bcd[11:8]);
            end
            HEX5 = seg_of({1'b0, conv_tag});
        end
    end

    assign HEX3 = SEG_BLANK;
    assign HEX4 = SEG_BLANK;
    assign LEDR = ledr_q;
    assign busy = conv_busy;

endmodule

// File: tb/tb_display_hex_pager.sv
// tb_display_hex_pager
// Directed testbench for display_hex_pager with DATA_W=8, NUM_CH=4,
// ROTATE_TICKS=8, FLASH_TICKS=4. Inputs are driven 1 time unit after the
// rising clock edge, and outputs are sampled at the same point.
module tb_display_hex_pager;

    localparam logic [6:0] S0 = 7'h40;
    localparam logic [6:0] S1 = 7'h79;
    localparam logic [6:0] S2 = 7'h24;
    localparam logic [6:0] S3 = 7'h30;
    localparam logic [6:0] S5 = 7'h12;
    localparam logic [6:0] S7 = 7'h78;
    localparam logic [6:0] BL = 7'h7F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ch_data = '0;
    logic        page_next = 1'b0;
    logic        auto_rotate = 1'b0;
    logic        match_signal = 1'b0;
    logic        halt_signal = 1'b0;
    logic [1:0]  state = 2'b00;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0]  LEDR;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    display_hex_pager #(
        .DATA_W      (8),
        .NUM_CH      (4),
        .ROTATE_TICKS(8),
        .FLASH_TICKS (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ch_data     (ch_data),
        .page_next   (page_next),
        .auto_rotate (auto_rotate),
        .match_signal(match_signal),
        .halt_signal (halt_signal),
        .state       (state),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3),
        .HEX4        (HEX4),
        .HEX5        (HEX5),
        .LEDR        (LEDR),
        .busy        (busy)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ch(input int idx, input logic [7:0] v);
        ch_data[idx*8 +: 8] = v;
    endtask

    task automatic pulse_page();
        page_next = 1'b1;
        tick(1);
        page_next = 1'b0;
    endtask

    task automatic test_reset();
        set_ch(0, 8'd50);
        set_ch(1, 8'd255);
        set_ch(2, 8'd0);
        set_ch(3, 8'd105);
        reset = 1'b1;
        tick(2);
        total_cnt++;
        if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{BL}})
            $display("FAIL reset_hex: got %h want %h", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{BL}});
        else pass_cnt++;
        total_cnt++;
        if (LEDR !== 10'h000) $display("FAIL reset_ledr: got %h want %h", LEDR, 10'h000);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else pass_cnt++;

        reset = 1'b0;
        tick(1);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL first_conv_busy: got %b want 1", busy);
        else pass_cnt++;
        tick(8);
        total_cnt++;
        if (HEX0 !== BL) $display("FAIL first_conv_early: HEX0 got %h want %h", HEX0, BL);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if ({HEX2, HEX1, HEX0} !== {BL, S5, S0})
            $display("FAIL first_conv_digits: got %h want %h", {HEX2, HEX1, HEX0}, {BL, S5, S0});
        else pass_cnt++;
        total_cnt++;
        if ({HEX5, HEX4, HEX3} !== {S0, BL, BL})
            $display("FAIL first_conv_page: got %h want %h", {HEX5, HEX4, HEX3}, {S0, BL, BL});
        else pass_cnt++;
        total_cnt++;
        if (LEDR !== 10'h010) $display("FAIL first_conv_ledr: got %h want %h", LEDR, 10'h010);
        else pass_cnt++;
    endtask

    task automatic test_page_next();
        logic [20:0] exp_dig [3];
        logic [6:0]  exp_pg  [3];
        logic [5:0]  exp_oh  [3];
        exp_dig = '{{BL, BL, S0}, {S1, S0, S5}, {BL, S5, S0}};
        exp_pg  = '{S2, S3, S0};
        exp_oh  = '{6'b000100, 6'b001000, 6'b000001};

        pulse_page();
        tick(8);
        total_cnt++;
        if (HEX5 !== S0) $display("FAIL page1_early: HEX5 got %h want %h", HEX5, S0);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if ({HEX2, HEX1, HEX0} !== {S2, S5, S5})
            $display("FAIL page1_digits: got %h want %h", {HEX2, HEX1, HEX0}, {S2, S5, S5});
        else pass_cnt++;
        total_cnt++;
        if (HEX5 !== S1) $display("FAIL page1_hex5: got %h want %h", HEX5, S1);
        else pass_cnt++;
        total_cnt++;
        if (LEDR[9:4] !== 6'b000010) $display("FAIL page1_led: got %b want %b", LEDR[9:4], 6'b000010);
        else pass_cnt++;

        for (int p = 0; p < 3; p++) begin
            pulse_page();
            tick(9);
            total_cnt++;
            if ({HEX2, HEX1, HEX0} !== exp_dig[p])
                $display("FAIL page_step%0d_digits: got %h want %h", p + 2, {HEX2, HEX1, HEX0}, exp_dig[p]);
            else pass_cnt++;
            total_cnt++;
            if (HEX5 !== exp_pg[p])
                $display("FAIL page_step%0d_hex5: got %h want %h", p + 2, HEX5, exp_pg[p]);
            else pass_cnt++;
            total_cnt++;
            if (LEDR[9:4] !== exp_oh[p])
                $display("FAIL page_step%0d_led: got %b want %b", p + 2, LEDR[9:4], exp_oh[p]);
            else pass_cnt++;
        end
    endtask

    task automatic test_auto_rotate();
        auto_rotate = 1'b1;
        tick(7);
        total_cnt++;
        if (LEDR[9:4] !== 6'b000001) $display("FAIL rotate_early: got %b want %b", LEDR[9:4], 6'b000001);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (LEDR[9:4] !== 6'b000010) $display("FAIL rotate_first: got %b want %b", LEDR[9:4], 6'b000010);
        else pass_cnt++;
        tick(7);
        total_cnt++;
        if (LEDR[9:4] !== 6'b000010) $display("FAIL rotate_hold: got %b want %b", LEDR[9:4], 6'b000010);
        else pass_cnt++;
        pulse_page();
        total_cnt++;
        if (LEDR[9:4] !== 6'b000100) $display("FAIL rotate_coincide: got %b want %b", LEDR[9:4], 6'b000100);
        else pass_cnt++;
        auto_rotate = 1'b0;
        tick(25);
        total_cnt++;
        if (LEDR[9:4] !== 6'b000100) $display("FAIL rotate_off: got %b want %b", LEDR[9:4], 6'b000100);
        else pass_cnt++;
        total_cnt++;
        if ({HEX5, HEX2, HEX1, HEX0} !== {S2, BL, BL, S0})
            $display("FAIL rotate_settle: got %h want %h", {HEX5, HEX2, HEX1, HEX0}, {S2, BL, BL, S0});
        else pass_cnt++;
        pulse_page();
        tick(1);
        pulse_page();
        tick(25);
        total_cnt++;
        if ({HEX5, HEX2, HEX1, HEX0} !== {S0, BL, S5, S0})
            $display("FAIL rotate_back: got %h want %h", {HEX5, HEX2, HEX1, HEX0}, {S0, BL, S5, S0});
        else pass_cnt++;
    endtask

    task automatic test_update_during_shift();
        logic [20:0] exp;
        logic        exp_busy;
        set_ch(0, 8'd7);
        tick(1);
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (i == 3) set_ch(0, 8'd200);
            if (i < 9)       exp = {BL, S5, S0};
            else if (i < 19) exp = {BL, BL, S7};
            else             exp = {S2, S0, S0};
            exp_busy = (i < 20);
            total_cnt++;
            if ({HEX2, HEX1, HEX0} !== exp)
                $display("FAIL shift_update_c%0d: got %h want %h", i, {HEX2, HEX1, HEX0}, exp);
            else pass_cnt++;
            total_cnt++;
            if (busy !== exp_busy)
                $display("FAIL shift_busy_c%0d: got %b want %b", i, busy, exp_busy);
            else pass_cnt++;
        end
    endtask

    task automatic test_match_halt();
        match_signal = 1'b1;
        tick(1);
        match_signal = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (LEDR[0] !== (i < 4))
                $display("FAIL match_stretch_c%0d: got %b want %b", i, LEDR[0], (i < 4));
            else pass_cnt++;
            tick(1);
        end

        state = 2'b10;
        tick(1);
        total_cnt++;
        if (LEDR[3:2] !== 2'b10) $display("FAIL state_led: got %b want 10", LEDR[3:2]);
        else pass_cnt++;
        state = 2'b00;

        halt_signal = 1'b1;
        tick(1);
        total_cnt++;
        if (LEDR[1] !== 1'b1) $display("FAIL halt_led: got %b want 1", LEDR[1]);
        else pass_cnt++;
        pulse_page();
        set_ch(0, 8'd33);
        tick(12);
        total_cnt++;
        if (LEDR[9:4] !== 6'b000001) $display("FAIL halt_page: got %b want %b", LEDR[9:4], 6'b000001);
        else pass_cnt++;
        total_cnt++;
        if ({HEX5, HEX2, HEX1, HEX0} !== {S0, S2, S0, S0})
            $display("FAIL halt_frozen: got %h want %h", {HEX5, HEX2, HEX1, HEX0}, {S0, S2, S0, S0});
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL halt_busy: got %b want 0", busy);
        else pass_cnt++;

        halt_signal = 1'b0;
        tick(1);
        total_cnt++;
        if (LEDR[1] !== 1'b0) $display("FAIL halt_release_led: got %b want 0", LEDR[1]);
        else pass_cnt++;
        tick(8);
        total_cnt++;
        if ({HEX2, HEX1, HEX0} !== {S2, S0, S0})
            $display("FAIL halt_release_early: got %h want %h", {HEX2, HEX1, HEX0}, {S2, S0, S0});
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if ({HEX2, HEX1, HEX0} !== {BL, S3, S3})
            $display("FAIL halt_release_conv: got %h want %h", {HEX2, HEX1, HEX0}, {BL, S3, S3});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        set_ch(0, 8'd123);
        tick(5);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL midreset_busy_before: got %b want 1", busy);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{BL}})
            $display("FAIL midreset_hex: got %h want %h", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{BL}});
        else pass_cnt++;
        total_cnt++;
        if (LEDR !== 10'h000) $display("FAIL midreset_ledr: got %h want %h", LEDR, 10'h000);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy);
        else pass_cnt++;
        tick(1);
        reset = 1'b0;
        tick(9);
        total_cnt++;
        if (HEX0 !== BL) $display("FAIL midreset_release_early: HEX0 got %h want %h", HEX0, BL);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if ({HEX5, HEX2, HEX1, HEX0} !== {S0, S1, S2, S3})
            $display("FAIL midreset_release_conv: got %h want %h", {HEX5, HEX2, HEX1, HEX0}, {S0, S1, S2, S3});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_page_next();
        test_auto_rotate();
        test_update_during_shift();
        test_match_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
